// File: rtl/handshake_demux_buf_if.sv
// Handshake bundle for handshake_demux_buf: selector, data input and NUM_OUT
// buffered outputs. The bench drives the master side, the demux takes the slave side.
interface handshake_demux_buf_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OUT = 4
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_OUT);

  logic                     sel_valid;
  logic                     sel_ready;
  logic [SEL_WIDTH-1:0]     sel_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic                     oob_err;

  modport master (
    output sel_valid, sel_data, in_valid, in_data, out_ready,
    input  sel_ready, in_ready, out_valid, out_data, oob_err
  );

  modport slave (
    input  sel_valid, sel_data, in_valid, in_data, out_ready,
    output sel_ready, in_ready, out_valid, out_data, oob_err
  );
endinterface

// File: rtl/handshake_demux_buf.sv
// N-way handshake branch: a selector/data token pair is routed into the chosen output's
// private FIFO. Optional drop of out-of-range selectors via HANDSHAKE_DEMUX_OOB_DROP_EN.
module handshake_demux_buf #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_demux_buf_if.slave bus
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_OUT);
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]   count  [NUM_OUT];
  logic [PTR_W-1:0]   wr_ptr [NUM_OUT];
  logic [PTR_W-1:0]   rd_ptr [NUM_OUT];
  logic [WIDTH-1:0]   mem    [NUM_OUT][DEPTH];
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic               in_range;
  logic               sel_full;
  logic               fire;
  logic               accept;

  // Pointer increment with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    full = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      full[i] = (count[i] == CNT_W'(DEPTH));
    end
  end

  // Fire decision; a full target never accepts, even when it pops this cycle.
  always_comb begin
    in_range = ({1'b0, bus.sel_data} < (SEL_WIDTH + 1)'(NUM_OUT));
    sel_full = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (bus.sel_data == SEL_WIDTH'(i)) sel_full = full[i];
    end
    fire = !rst && bus.sel_valid && bus.in_valid && in_range && !sel_full;
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      push[i] = fire && (bus.sel_data == SEL_WIDTH'(i));
      pop[i]  = (count[i] != '0) && bus.out_ready[i];
    end
  end

`ifdef HANDSHAKE_DEMUX_OOB_DROP_EN
  logic drop;
  logic oob_err_q;

  assign drop   = !rst && bus.sel_valid && bus.in_valid && !in_range;
  assign accept = fire || drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       oob_err_q <= 1'b0;
    else if (drop) oob_err_q <= 1'b1;
  end

  assign bus.oob_err = oob_err_q;
`else
  assign accept      = fire;
  assign bus.oob_err = 1'b0;
`endif

  assign bus.sel_ready = accept;
  assign bus.in_ready  = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  // Storage is intentionally not reset; out_data is don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (push[i] && (wr_ptr[i] == PTR_W'(j))) mem[i][j] <= bus.in_data;
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      bus.out_valid[i] = (count[i] != '0);
      for (int j = 0; j < DEPTH; j++) begin
        if (rd_ptr[i] == PTR_W'(j)) bus.out_data[i*WIDTH +: WIDTH] = mem[i][j];
      end
    end
  end
endmodule

// File: tb/tb_handshake_demux_buf.sv
// Scoreboard bench for handshake_demux_buf: a 4-way DEPTH=2 instance and a 3-way DEPTH=1
// instance (out-of-range selector and half-rate streaming).
module tb_handshake_demux_buf;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  handshake_demux_buf_if #(.WIDTH(32), .NUM_OUT(4)) ba ();
  handshake_demux_buf_if #(.WIDTH(8),  .NUM_OUT(3)) bb ();

  handshake_demux_buf #(.WIDTH(32), .NUM_OUT(4), .DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  handshake_demux_buf #(.WIDTH(8),  .NUM_OUT(3), .DEPTH(1)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  logic [31:0] qa [4][$];
  logic [7:0]  qb [3][$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: every pop the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (ba.out_valid[i] && ba.out_ready[i]) begin
          if (qa[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_a%0d: got unexpected token %0h expected none", i, ba.out_data[i*32 +: 32]);
          end else begin
            check($sformatf("mon_a%0d", i), ba.out_data[i*32 +: 32], qa[i].pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (bb.out_valid[i] && bb.out_ready[i]) begin
          if (qb[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_b%0d: got unexpected token %0h expected none", i, bb.out_data[i*8 +: 8]);
          end else begin
            check($sformatf("mon_b%0d", i), 32'(bb.out_data[i*8 +: 8]), 32'(qb[i].pop_front()));
          end
        end
      end
    end
  end

  // One cycle on instance A: drive at posedge+1, check readies/out_valid at negedge.
  task automatic step_a(input logic v, input logic [1:0] sel, input logic [31:0] d,
                        input logic rdy, input logic [3:0] ov, input string nm);
    ba.sel_valid = v; ba.in_valid = v; ba.sel_data = sel; ba.in_data = d;
    @(negedge clk);
    check({nm, " rdy"}, 32'({ba.sel_ready, ba.in_ready, ba.oob_err}), 32'({rdy, rdy, 1'b0}));
    check({nm, " ov"}, 32'(ba.out_valid), 32'(ov));
    if (rdy) qa[sel].push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [1:0] sel, input logic [7:0] d,
                        input logic rdy, input logic [2:0] ov, input logic oob, input string nm);
    bb.sel_valid = v; bb.in_valid = v; bb.sel_data = sel; bb.in_data = d;
    @(negedge clk);
    check({nm, " rdy"}, 32'({bb.sel_ready, bb.in_ready, bb.oob_err}), 32'({rdy, rdy, oob}));
    check({nm, " ov"}, 32'(bb.out_valid), 32'(ov));
    if (rdy && sel < 2'd3) qb[sel].push_back(d);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ba.sel_valid = 1'b1; ba.in_valid = 1'b1; ba.sel_data = 2'd2; ba.in_data = 32'hDEAD_BEEF;
    ba.out_ready = 4'hF;
    bb.sel_valid = 1'b0; bb.in_valid = 1'b0; bb.sel_data = '0; bb.in_data = '0;
    bb.out_ready = 3'h7;

    // Reset state: readies held low even with both inputs valid
    @(negedge clk);
    check("rst rdy_a", 32'({ba.sel_ready, ba.in_ready, ba.oob_err}), 32'd0);
    check("rst ov_a", 32'(ba.out_valid), 32'd0);
    check("rst ov_b", 32'({bb.out_valid, bb.oob_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic route to output 2
    step_a(1'b1, 2'd2, 32'hA5A5_A5A5, 1'b1, 4'b0000, "route c0");
    step_a(1'b0, 2'd0, 32'h0,         1'b0, 4'b0100, "route c1");
    step_a(1'b0, 2'd0, 32'h0,         1'b0, 4'b0000, "route c2");

    // Back-pressure isolation: output 1 stalled
    ba.out_ready = 4'b1101;
    step_a(1'b1, 2'd1, 32'h11, 1'b1, 4'b0000, "bp t0");
    step_a(1'b1, 2'd1, 32'h12, 1'b1, 4'b0010, "bp t1");
    step_a(1'b1, 2'd1, 32'h13, 1'b0, 4'b0010, "bp t2 stall");
    step_a(1'b1, 2'd3, 32'h31, 1'b1, 4'b0010, "bp t3");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b1010, "bp out3");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0010, "bp hold");
    ba.out_ready = 4'hF;
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0010, "bp drain0");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0010, "bp drain1");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0000, "bp empty");

    // Full with concurrent pop on output 0
    ba.out_ready = 4'b1110;
    step_a(1'b1, 2'd0, 32'h1, 1'b1, 4'b0000, "fp w1");
    step_a(1'b1, 2'd0, 32'h2, 1'b1, 4'b0001, "fp w2");
    ba.out_ready = 4'hF;
    step_a(1'b1, 2'd0, 32'h3, 1'b0, 4'b0001, "fp full");
    step_a(1'b1, 2'd0, 32'h3, 1'b1, 4'b0001, "fp w3");
    step_a(1'b0, 2'd0, 32'h0, 1'b0, 4'b0001, "fp last");
    step_a(1'b0, 2'd0, 32'h0, 1'b0, 4'b0000, "fp empty");

    // Streaming at full rate into output 0
    step_a(1'b1, 2'd0, 32'd0, 1'b1, 4'b0000, "st0");
    for (int k = 1; k < 8; k++) step_a(1'b1, 2'd0, 32'(k), 1'b1, 4'b0001, $sformatf("st%0d", k));
    step_a(1'b0, 2'd0, 32'h0, 1'b0, 4'b0001, "st tail");
    step_a(1'b0, 2'd0, 32'h0, 1'b0, 4'b0000, "st empty");

    // Mid-stream asynchronous reset with two tokens held on output 2
    ba.out_ready = 4'b1011;
    step_a(1'b1, 2'd2, 32'h21, 1'b1, 4'b0000, "mr w0");
    step_a(1'b1, 2'd2, 32'h22, 1'b1, 4'b0100, "mr w1");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0100, "mr hold");
    #2 rst = 1'b1;
    #1 check("mr async ov", 32'(ba.out_valid), 32'd0);
    rst = 1'b0;
    qa[2].delete();
    @(posedge clk); #1;
    ba.out_ready = 4'hF;
    step_a(1'b1, 2'd2, 32'h77, 1'b1, 4'b0000, "mr fresh");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0100, "mr alone");
    step_a(1'b0, 2'd0, 32'h0,  1'b0, 4'b0000, "mr empty");

    // DEPTH=1: one fire every two cycles
    step_b(1'b1, 2'd0, 8'h10, 1'b1, 3'b000, 1'b0, "d1 f0");
    step_b(1'b1, 2'd0, 8'h11, 1'b0, 3'b001, 1'b0, "d1 s1");
    step_b(1'b1, 2'd0, 8'h11, 1'b1, 3'b000, 1'b0, "d1 f1");
    step_b(1'b1, 2'd0, 8'h12, 1'b0, 3'b001, 1'b0, "d1 s2");
    step_b(1'b1, 2'd0, 8'h12, 1'b1, 3'b000, 1'b0, "d1 f2");
    step_b(1'b1, 2'd2, 8'h42, 1'b1, 3'b001, 1'b0, "d1 o2");
    step_b(1'b0, 2'd0, 8'h00, 1'b0, 3'b100, 1'b0, "d1 tail");
    step_b(1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b0, "d1 empty");

    // Out-of-range selector on the 3-way instance
`ifdef HANDSHAKE_DEMUX_OOB_DROP_EN
    step_b(1'b1, 2'd3, 8'h99, 1'b1, 3'b000, 1'b0, "oob drop");
    for (int k = 0; k < 4; k++) step_b(1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b1, "oob sticky");
    rst = 1'b1;
    #2 check("oob rst", 32'(bb.oob_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
`else
    for (int k = 0; k < 20; k++) step_b(1'b1, 2'd3, 8'h99, 1'b0, 3'b000, 1'b0, "oob stall");
`endif
    step_b(1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b0, "oob idle");

    for (int i = 0; i < 4; i++) check($sformatf("qa%0d left", i), 32'(qa[i].size()), 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("qb%0d left", i), 32'(qb[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/handshake_demux_buf.md
# handshake_demux_buf

Parametrised N-way handshake branch with per-output elastic buffering. A data token and a selector token are consumed together and routed to output `sel_data`, where they enter that output's private FIFO. Outputs are decoupled from each other and from the input, so one stalled consumer does not block traffic to the others. This block generalises the two-way conditional branch to `NUM_OUT` destinations and sits between dataflow operators and fan-out points in the handshake fabric.

## Interface
- `WIDTH`, default 32: data width in bits, ≥1.
- `NUM_OUT`, default 4: number of outputs, ≥2.
- `DEPTH`, default 2: entries per output FIFO, ≥1.
- `SEL_WIDTH`, default `$clog2(NUM_OUT)`: selector width. Derived; do not override.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `sel_valid` input 1, `sel_ready` output 1, `sel_data` input `SEL_WIDTH`: selector channel.
- `in_valid` input 1, `in_ready` output 1, `in_data` input `WIDTH`: data channel.
- `out_valid` output `NUM_OUT`: per-output valid.
- `out_ready` input `NUM_OUT`: per-output ready.
- `out_data` output `NUM_OUT*WIDTH`: output i occupies bits `[i*WIDTH +: WIDTH]`.
- `oob_err` output 1: sticky out-of-range-selector flag (see Configuration).

## Operation
- `in_range` = `sel_data < NUM_OUT`.
- `full[i]` = (`count[i] == DEPTH`).
- Fire: `fire` = `sel_valid && in_valid && in_range && !full[sel_data]`.
  - `sel_ready = in_ready = fire`. Both channels are consumed in the same cycle or not at all.
  - Ready may depend on valid, as elsewhere in the handshake library.
- On fire, `in_data` is written to FIFO `sel_data` at its write pointer. The write pointer advances and the count increments.
- Output i: `out_valid[i] = (count[i] != 0)`. The `out_data` slice is the FIFO head.
  - Pop when `out_valid[i] && out_ready[i]`: the read pointer advances and the count decrements.
- Push and pop on the same FIFO in the same cycle: the count is unchanged and both pointers advance.
  - A full FIFO never accepts a push, even if it pops that cycle. This keeps `out_ready` off the `in_ready` path.
- Pointers wrap modulo `DEPTH`. For non-power-of-2 `DEPTH`, wrap explicitly at `DEPTH-1 → 0`.
- Count width is `$clog2(DEPTH+1)`.
- Per-output order is preserved. Tokens to different outputs carry no ordering relation.
- `sel_data` is ignored unless `sel_valid && in_valid`.
- Out-of-range selector: behaviour depends on the macro (see Configuration). Out-of-range is only possible when `NUM_OUT` is not a power of 2.

## Timing
- Reset (asynchronous assert; release takes effect at the next `clk` edge):
  - all counts and pointers are 0;
  - `out_valid` is all 0;
  - `oob_err` is 0.
  - `sel_ready` and `in_ready` are combinational and are 0 while `rst` is high.
  - FIFO storage is not reset; `out_data` is don't-care while `out_valid` is 0.
- Reset asserted mid-operation discards all buffered tokens immediately. No pops are reported.
- Latency: a token fired at edge k is visible on `out_valid` and `out_data` after edge k (cycle k+1). There is no combinational input-to-output path.
- Throughput: 1 token/cycle per output when `DEPTH ≥ 2` and the consumer is always ready. With `DEPTH = 1`, throughput is 1 token per 2 cycles.
- `out_valid[i]` stays high, with stable data, until popped.

## Configuration
- `HANDSHAKE_DEMUX_OOB_DROP_EN` defined:
  - An out-of-range selector with both inputs valid fires the drop path: `sel_ready = in_ready = 1` and the token is discarded.
  - `oob_err` sets at that edge and stays set until `rst`.
- Macro not defined:
  - An out-of-range selector is never consumed; both readies stay 0 and the inputs stall indefinitely.
  - `oob_err` is tied to 0.

## Test plan
- Reset and basic route (`NUM_OUT=4`, `DEPTH=2`): `sel=2`, `data=0xA5A5A5A5`, both valid for one cycle, all `out_ready=1`. Required: fire in cycle 0; `out_valid=4'b0100` and slice 2 = `0xA5A5A5A5` in cycle 1; `out_valid=0` in cycle 2.
- Back-pressure isolation: `out_ready[1]=0`; send 3 tokens to output 1, then 1 token to output 3. Required: the first 2 fire; the third stalls with `in_ready=0`. Then set `sel=3` and it fires. `out_valid[3]` rises while output 1 stays full at `count=2`.
- Full with concurrent pop: output 0 full, `out_ready[0]=1`, a new token targets 0. Required: no fire that cycle; pop occurs; fire next cycle. Tokens exit in order 0x1, 0x2, 0x3.
- Streaming: 8 tokens 0..7 to output 0 on consecutive cycles, `out_ready[0]=1`, `DEPTH=2`. Required: one fire per cycle, outputs 0..7 in cycles 1..8. Repeat with `DEPTH=1`: one fire every 2 cycles.
- Out-of-range (`NUM_OUT=3`, `sel=3`):
  - With macro: consumed in 1 cycle, no `out_valid`, `oob_err=1` persisting until `rst`.
  - Without macro: readies stay 0 for 20 cycles and `oob_err=0`.
- Mid-stream reset: with 2 tokens buffered on output 2, pulse `rst` asynchronously between edges. Required: `out_valid` goes to 0 immediately; after release, a fresh token to output 2 appears alone.
